// File: rtl/signal_timing_controller_pkg.sv
// Light-controller state and phase encodings shared with the interchange light controller,
// plus the timing controller's types and its phase-selection rule.
`ifndef SIGNAL_FSM_PARAMS
`define SIGNAL_FSM_PARAMS
`define ALL_RED          4'd0
`define PHASE_1_GREEN    4'd1
`define PHASE_1_YELLOW   4'd2
`define PHASE_2_GREEN    4'd3
`define PHASE_2_YELLOW   4'd4
`define EASTBOUND_GREEN  4'd5
`define EASTBOUND_YELLOW 4'd6
`define WESTBOUND_GREEN  4'd7
`define WESTBOUND_YELLOW 4'd8
`define MAINTENANCE      4'd9
`define PHASE_1          2'd0
`define PHASE_2          2'd1
`define EAST_PRIORITY    2'd2
`define WEST_PRIORITY    2'd3
`define DIR_EAST         1'b0
`define DIR_WEST         1'b1
`endif

package signal_timing_controller_pkg;

    typedef enum logic [3:0] {
        ST_ALL_RED     = `ALL_RED,
        ST_P1_GREEN    = `PHASE_1_GREEN,
        ST_P1_YELLOW   = `PHASE_1_YELLOW,
        ST_P2_GREEN    = `PHASE_2_GREEN,
        ST_P2_YELLOW   = `PHASE_2_YELLOW,
        ST_EB_GREEN    = `EASTBOUND_GREEN,
        ST_EB_YELLOW   = `EASTBOUND_YELLOW,
        ST_WB_GREEN    = `WESTBOUND_GREEN,
        ST_WB_YELLOW   = `WESTBOUND_YELLOW,
        ST_MAINTENANCE = `MAINTENANCE
    } light_state_t;

    typedef enum logic [1:0] {
        PH_1    = `PHASE_1,
        PH_2    = `PHASE_2,
        PH_EAST = `EAST_PRIORITY,
        PH_WEST = `WEST_PRIORITY
    } phase_t;

    localparam logic DIR_EAST = `DIR_EAST;
    localparam logic DIR_WEST = `DIR_WEST;

    // Priority requests beat normal alternation; simultaneous requests take turns.
    function automatic phase_t choose_phase(input logic   east_pend,
                                            input logic   west_pend,
                                            input logic   last_prio,
                                            input phase_t last_normal);
        if (east_pend && west_pend) return (last_prio == DIR_EAST) ? PH_WEST : PH_EAST;
        if (east_pend)              return PH_EAST;
        if (west_pend)              return PH_WEST;
        return (last_normal == PH_1) ? PH_2 : PH_1;
    endfunction

endpackage

// File: rtl/signal_timing_controller_second_ticker.sv
// Prescaler plus whole-seconds down-counter. The load cycle counts as prescaler step zero,
// and final_next flags that the coming cycle is the last one of the loaded interval.
module second_ticker #(
    parameter int CLK_DIV   = 4,
    parameter int SEC_W     = 8,
    parameter int RESET_SEC = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             load,
    input  logic             enable,
    input  logic [SEC_W-1:0] load_value,
    output logic [SEC_W-1:0] sec_remaining,
    output logic             final_next
);

    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);

    logic [PW-1:0]    presc;
    logic [PW-1:0]    presc_base;
    logic [PW-1:0]    presc_next;
    logic [SEC_W-1:0] secs_base;
    logic [SEC_W-1:0] secs_next;

    always_comb begin
        // NOTE: every output of this block gets a default first so no path can infer a latch.
        presc_base = load ? '0 : presc;
        secs_base  = load ? load_value : sec_remaining;
        presc_next = presc;
        secs_next  = sec_remaining;
        if (clear) begin
            presc_next = '0;
            secs_next  = '0;
        end else if (load || enable) begin
            if (presc_base == PRESC_MAX) begin
                presc_next = '0;
                secs_next  = (secs_base != '0) ? secs_base - 1'b1 : secs_base;
            end else begin
                presc_next = presc_base + 1'b1;
                secs_next  = secs_base;
            end
        end
    end

    assign final_next = !clear && (load || enable) &&
                        (secs_next == SEC_W'(1)) && (presc_next == PRESC_MAX);

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state registers use non-blocking assignments so all flops update together.
        if (rst) begin
            presc         <= '0;
            sec_remaining <= SEC_W'(RESET_SEC);
        end else begin
            presc         <= presc_next;
            sec_remaining <= secs_next;
        end
    end

endmodule

// File: rtl/signal_timing_controller.sv
// Times each light state from a seconds ticker, pulses timing_done on expiry, and picks the
// phase the light controller takes when it leaves ALL_RED.
module signal_timing_controller
    import signal_timing_controller_pkg::*;
#(
    parameter int CLK_DIV        = 4,
    parameter int GREEN_SEC      = 3,
    parameter int PRIO_GREEN_SEC = 2,
    parameter int YELLOW_SEC     = 2,
    parameter int ALL_RED_SEC    = 1,
    parameter int SEC_W          = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       current_state,
    input  logic             maintenance,
    input  logic             east_req,
    input  logic             west_req,
    output logic             timing_done,
    output logic [1:0]       phase,
    output logic [SEC_W-1:0] sec_remaining
);

    logic [3:0]       prev_state;
    logic             fresh;
    logic             armed;
    logic             east_pend;
    logic             west_pend;
    logic             last_prio;
    phase_t           phase_q;
    phase_t           last_normal;
    logic             maint;
    logic             entry;
    logic             final_next;
    logic [SEC_W-1:0] duration;

    function automatic logic [SEC_W-1:0] state_seconds(input logic [3:0] state);
        case (state)
            ST_P1_GREEN, ST_P2_GREEN:                 return SEC_W'(GREEN_SEC);
            ST_EB_GREEN, ST_WB_GREEN:                 return SEC_W'(PRIO_GREEN_SEC);
            ST_P1_YELLOW, ST_P2_YELLOW,
            ST_EB_YELLOW, ST_WB_YELLOW:               return SEC_W'(YELLOW_SEC);
            default:                                  return SEC_W'(ALL_RED_SEC);
        endcase
    endfunction

    // fresh forces an entry after reset or maintenance even when the state code is unchanged.
    assign maint    = maintenance || (current_state == ST_MAINTENANCE);
    assign entry    = !maint && (fresh || (current_state != prev_state));
    assign duration = state_seconds(current_state);
    assign phase    = phase_q;

    second_ticker #(
        .CLK_DIV   (CLK_DIV),
        .SEC_W     (SEC_W),
        .RESET_SEC (ALL_RED_SEC)
    ) u_ticker (
        .clk           (clk),
        .rst           (rst),
        .clear         (maint),
        .load          (entry),
        .enable        (armed),
        .load_value    (duration),
        .sec_remaining (sec_remaining),
        .final_next    (final_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_state  <= ST_ALL_RED;
            fresh       <= 1'b1;
            armed       <= 1'b0;
            timing_done <= 1'b0;
            phase_q     <= PH_1;
            east_pend   <= 1'b0;
            west_pend   <= 1'b0;
            last_normal <= PH_2;
            last_prio   <= DIR_WEST;
        end else begin
            prev_state <= current_state;
            if (maint) begin
                fresh       <= 1'b1;
                armed       <= 1'b0;
                timing_done <= 1'b0;
                phase_q     <= PH_1;
                east_pend   <= 1'b0;
                west_pend   <= 1'b0;
                last_normal <= PH_2;
            end else begin
                fresh       <= 1'b0;
                timing_done <= final_next;
                if (entry)
                    armed <= 1'b1;
                else if (timing_done)
                    armed <= 1'b0;
                // A request in the same cycle as the clearing entry still leaves the bit set.
                east_pend <= east_req || (east_pend && !(entry && current_state == ST_EB_GREEN));
                west_pend <= west_req || (west_pend && !(entry && current_state == ST_WB_GREEN));
                if (entry) begin
                    case (current_state)
                        ST_ALL_RED:  phase_q     <= choose_phase(east_pend, west_pend, last_prio, last_normal);
                        ST_P1_GREEN: last_normal <= PH_1;
                        ST_P2_GREEN: last_normal <= PH_2;
                        ST_EB_GREEN: last_prio   <= DIR_EAST;
                        ST_WB_GREEN: last_prio   <= DIR_WEST;
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_signal_timing_controller.sv
// Directed bench: stimulus queues the expected cycle and phase of every timing_done pulse,
// and a negedge monitor pops and compares whenever the controller pulses.
module tb_signal_timing_controller;
    import signal_timing_controller_pkg::*;

    localparam int CLK_DIV        = 4;
    localparam int GREEN_SEC      = 3;
    localparam int PRIO_GREEN_SEC = 2;
    localparam int YELLOW_SEC     = 2;
    localparam int ALL_RED_SEC    = 1;
    localparam int SEC_W          = 8;

    typedef struct {
        int         cyc;
        logic [1:0] ph;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [3:0]       current_state = ST_ALL_RED;
    logic             maintenance = 1'b0;
    logic             east_req = 1'b0;
    logic             west_req = 1'b0;
    logic             timing_done;
    logic [1:0]       phase;
    logic [SEC_W-1:0] sec_remaining;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    exp_t exp_q[$];

    signal_timing_controller #(
        .CLK_DIV        (CLK_DIV),
        .GREEN_SEC      (GREEN_SEC),
        .PRIO_GREEN_SEC (PRIO_GREEN_SEC),
        .YELLOW_SEC     (YELLOW_SEC),
        .ALL_RED_SEC    (ALL_RED_SEC),
        .SEC_W          (SEC_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .current_state (current_state),
        .maintenance   (maintenance),
        .east_req      (east_req),
        .west_req      (west_req),
        .timing_done   (timing_done),
        .phase         (phase),
        .sec_remaining (sec_remaining)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached at cycle %0d, required completion earlier", cyc);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (timing_done) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_pulse: timing_done=1 at cycle %0d, expected no pulse", cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("pulse_cycle", cyc, e.cyc);
                check("pulse_sec", int'(sec_remaining), 1);
                check("pulse_phase", int'(phase), int'(e.ph));
            end
        end
    end

    // Called right after an entry: queue the expected pulse and wait (bounded) for it.
    task automatic expect_after(input int dsec, input logic [1:0] ph,
                                input int req_at, input logic e_r, input logic w_r);
        exp_t e;
        bit   got;
        got   = 1'b0;
        e.cyc = cyc + dsec * CLK_DIV - 1;
        e.ph  = ph;
        exp_q.push_back(e);
        for (int j = 0; j < dsec * CLK_DIV + 8; j++) begin
            @(negedge clk);
            if (j == req_at) begin
                east_req = e_r;
                west_req = w_r;
            end
            if (j == req_at + 1) begin
                east_req = 1'b0;
                west_req = 1'b0;
            end
            if (j == 1) check("sec_load", int'(sec_remaining), dsec);
            if (j == CLK_DIV + 1 && dsec > 1) check("sec_step", int'(sec_remaining), dsec - 1);
            if (timing_done) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            n_checks++;
            n_fail++;
            $display("FAIL pulse_timeout: no timing_done seen, expected at cycle %0d", e.cyc);
            if (exp_q.size() > 0) e = exp_q.pop_back();
        end
        @(posedge clk);
        #2;
    endtask

    task automatic enter(input logic [3:0] st, input int dsec, input logic [1:0] ph,
                         input int req_at, input logic e_r, input logic w_r);
        current_state = st;
        expect_after(dsec, ph, req_at, e_r, w_r);
    endtask

    initial begin
        int cnt;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_timing_done", int'(timing_done), 0);
        check("rst_phase", int'(phase), int'(PH_1));
        check("rst_sec", int'(sec_remaining), ALL_RED_SEC);

        // Release into ALL_RED: fresh entry, one pulse only
        @(posedge clk);
        #2;
        rst = 1'b0;
        expect_after(ALL_RED_SEC, PH_1, -1, 1'b0, 1'b0);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (timing_done) cnt++;
        end
        check("no_second_pulse", cnt, 0);
        @(posedge clk);
        #2;

        // Normal cycle: 12 / 8 / 4 spacing, then alternation to phase 2
        enter(ST_P1_GREEN,  GREEN_SEC,   PH_1, -1, 1'b0, 1'b0);
        enter(ST_P1_YELLOW, YELLOW_SEC,  PH_1, -1, 1'b0, 1'b0);
        enter(ST_ALL_RED,   ALL_RED_SEC, PH_2, -1, 1'b0, 1'b0);

        // Both requests together: east first (last priority was west), then west, then normal
        enter(ST_P2_GREEN,  GREEN_SEC,      PH_2,    2, 1'b1, 1'b1);
        enter(ST_P2_YELLOW, YELLOW_SEC,     PH_2,   -1, 1'b0, 1'b0);
        enter(ST_ALL_RED,   ALL_RED_SEC,    PH_EAST, -1, 1'b0, 1'b0);
        enter(ST_EB_GREEN,  PRIO_GREEN_SEC, PH_EAST, -1, 1'b0, 1'b0);
        enter(ST_EB_YELLOW, YELLOW_SEC,     PH_EAST, -1, 1'b0, 1'b0);
        enter(ST_ALL_RED,   ALL_RED_SEC,    PH_WEST, -1, 1'b0, 1'b0);
        enter(ST_WB_GREEN,  PRIO_GREEN_SEC, PH_WEST, -1, 1'b0, 1'b0);
        enter(ST_WB_YELLOW, YELLOW_SEC,     PH_WEST, -1, 1'b0, 1'b0);
        enter(ST_ALL_RED,   ALL_RED_SEC,    PH_1,    -1, 1'b0, 1'b0);

        // Single east request during phase 2 green
        enter(ST_P1_GREEN,  GREEN_SEC,      PH_1,    -1, 1'b0, 1'b0);
        enter(ST_P1_YELLOW, YELLOW_SEC,     PH_1,    -1, 1'b0, 1'b0);
        enter(ST_ALL_RED,   ALL_RED_SEC,    PH_2,    -1, 1'b0, 1'b0);
        enter(ST_P2_GREEN,  GREEN_SEC,      PH_2,     3, 1'b1, 1'b0);
        enter(ST_P2_YELLOW, YELLOW_SEC,     PH_2,    -1, 1'b0, 1'b0);
        enter(ST_ALL_RED,   ALL_RED_SEC,    PH_EAST, -1, 1'b0, 1'b0);
        enter(ST_EB_GREEN,  PRIO_GREEN_SEC, PH_EAST, -1, 1'b0, 1'b0);
        check("east_pend_cleared", int'(dut.east_pend), 0);
        enter(ST_EB_YELLOW, YELLOW_SEC,     PH_EAST, -1, 1'b0, 1'b0);
        // West request raised inside ALL_RED must not change this ALL_RED's phase
        enter(ST_ALL_RED,   ALL_RED_SEC,    PH_1,     1, 1'b0, 1'b1);
        enter(ST_P1_GREEN,  GREEN_SEC,      PH_1,    -1, 1'b0, 1'b0);
        enter(ST_P1_YELLOW, YELLOW_SEC,     PH_1,    -1, 1'b0, 1'b0);
        enter(ST_ALL_RED,   ALL_RED_SEC,    PH_WEST, -1, 1'b0, 1'b0);

        // Maintenance in the middle of westbound green
        current_state = ST_WB_GREEN;
        repeat (3) @(posedge clk);
        #2;
        maintenance = 1'b1;
        cnt = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (i == 2) east_req = 1'b1;
            if (i == 3) east_req = 1'b0;
            if (timing_done) cnt++;
        end
        check("maint_no_pulse", cnt, 0);
        check("maint_phase", int'(phase), int'(PH_1));
        check("maint_sec", int'(sec_remaining), 0);
        @(posedge clk);
        #2;
        current_state = ST_ALL_RED;
        @(posedge clk);
        #2;
        maintenance = 1'b0;
        expect_after(ALL_RED_SEC, PH_1, -1, 1'b0, 1'b0);

        // Reset two cycles before a phase 2 green would expire
        enter(ST_P1_GREEN,  GREEN_SEC,   PH_1, -1, 1'b0, 1'b0);
        enter(ST_P1_YELLOW, YELLOW_SEC,  PH_1, -1, 1'b0, 1'b0);
        enter(ST_ALL_RED,   ALL_RED_SEC, PH_2, -1, 1'b0, 1'b0);
        current_state = ST_P2_GREEN;
        repeat (9) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_timing_done", int'(timing_done), 0);
        check("midrst_phase", int'(phase), int'(PH_1));
        check("midrst_sec", int'(sec_remaining), ALL_RED_SEC);
        check("midrst_presc", int'(dut.u_ticker.presc), 0);
        check("midrst_pend", int'({dut.east_pend, dut.west_pend}), 0);
        repeat (4) @(negedge clk);
        @(posedge clk);
        #2;
        current_state = ST_ALL_RED;
        rst = 1'b0;
        expect_after(ALL_RED_SEC, PH_1, -1, 1'b0, 1'b0);

        repeat (4) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/signal_timing_controller.md
Name: signal_timing_controller

Overview:
Produces the `timing_done` strobe and the encoded `phase` that drive the interchange light controller, and consumes that controller's `current_state` as its only view of the intersection. It times every light state (green, yellow, all-red) from a prescaled seconds counter. It also chooses the next movement phase: normal alternation between PHASE_1 and PHASE_2, preempted by latched east/west priority requests. It sits beside the light controller at the top level and closes the timing loop.

Parameters:
CLK_DIV, 4, clk cycles per one-second tick (>=1)
GREEN_SEC, 3, seconds for PHASE_1_GREEN / PHASE_2_GREEN (>=1)
PRIO_GREEN_SEC, 2, seconds for EASTBOUND_GREEN / WESTBOUND_GREEN (>=1)
YELLOW_SEC, 2, seconds for every *_YELLOW state (>=1)
ALL_RED_SEC, 1, seconds for ALL_RED (>=1)
SEC_W, 8, width of seconds counter; all *_SEC must be < 2**SEC_W

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
current_state  in  4  light controller state, encoded with the shared state macros
maintenance  in  1  maintenance request, same signal the light controller receives
east_req  in  1  eastbound priority request; level, sampled every cycle
west_req  in  1  westbound priority request; level, sampled every cycle
timing_done  out  1  one-cycle pulse: the current state's time has expired
phase  out  2  registered phase selection for the next ALL_RED exit
sec_remaining  out  SEC_W  whole seconds left in the current state, for the countdown display

Behaviour:
- Reset values: timing_done=0; phase=`PHASE_1; sec_remaining=ALL_RED_SEC; east/west pending=0; last-normal=PHASE_2; last-priority=WEST; prescaler=0; prev_state=`ALL_RED.
- Entry detection: entry cycle E is the first cycle with current_state != prev_state. prev_state follows current_state every cycle. The first cycle after reset deassertion is an ALL_RED entry cycle.
- Duration D (seconds) by state: green -> GREEN_SEC; priority green -> PRIO_GREEN_SEC; yellow -> YELLOW_SEC; ALL_RED and any undefined encoding -> ALL_RED_SEC.
- timing_done is high for exactly one cycle, at E + D*CLK_DIV - 1, so each state lasts D*CLK_DIV cycles.
- After the pulse the timer disarms. No further pulse occurs until the next entry cycle, even if current_state is held.
- The prescaler clears at E and wraps at CLK_DIV-1. sec_remaining loads D at E and decrements on each wrap; it reads 1 during the pulse cycle and never underflows.
- Maintenance: while maintenance=1 or current_state=`MAINTENANCE, timing_done=0, prescaler cleared, sec_remaining=0, pending bits cleared, phase=`PHASE_1, last-normal=PHASE_2. The ALL_RED that follows maintenance is a fresh entry.
- Pending latches: east_pend sets on any cycle east_req=1 and clears on entry to EASTBOUND_GREEN. west_pend mirrors this with west_req and WESTBOUND_GREEN. If a set and a clear land in the same cycle, set wins.
- Phase choice is made on the ALL_RED entry cycle and registered, so phase is valid from E+1 and stable for the whole ALL_RED.
- Priority order at that choice:
  - only east_pend -> `EAST_PRIORITY
  - only west_pend -> `WEST_PRIORITY
  - both pending -> the direction other than last-priority
  - neither pending -> the normal phase other than last-normal
- last-normal updates on entry to PHASE_x_GREEN; last-priority updates on entry to a priority green.
- Requests arriving during ALL_RED do not alter phase until the next ALL_RED entry.
- Mid-operation reset returns every register to its reset value immediately, with no pulse.

Decomposition:
- Shared fsm parameters include: the state macros (ALL_RED … MAINTENANCE) and phase macros (PHASE_1, PHASE_2, EAST_PRIORITY, WEST_PRIORITY), reused unchanged.
- Add a DIR_EAST/DIR_WEST constant pair there.
- One natural sub-module: `second_ticker` (prescaler + down-counter with load/enable/tick), instantiated once.

Test Plan:
- Reset, hold current_state=`ALL_RED, defaults: timing_done pulses once at cycle 4 after release; sec_remaining=1 on that cycle; phase=`PHASE_1; no second pulse over 20 cycles.
- Drive PHASE_1_GREEN -> PHASE_1_YELLOW -> ALL_RED, each on the cycle after the pulse: pulses spaced 12, then 8, then 4 cycles apart; the second ALL_RED shows phase=`PHASE_2.
- Pulse east_req for 1 cycle during PHASE_2_GREEN: next ALL_RED gives phase=`EAST_PRIORITY; after EASTBOUND_GREEN entry east_pend=0 and the following ALL_RED gives `PHASE_1.
- Raise east_req and west_req together: successive ALL_REDs give `EAST_PRIORITY, then `WEST_PRIORITY, then a normal phase.
- Assert maintenance mid-green: timing_done stays 0 and phase=`PHASE_1. Drop maintenance with state ALL_RED: pulse arrives 4 cycles later.
- Assert rst 2 cycles before an expected pulse: no pulse, and all outputs return to reset values within the same cycle.
